// File: rtl/sales_pkg.sv
// Shared definitions for the vending-machine sales bookkeeping stage.
// Contents:
//   NUM_PRODUCTS        number of product slots (4)
//   prod_id_t           2-bit product index
//   qty_t               4-bit quantity (stock and sold count)
//   sale_state_t        sale FSM states IDLE, CHECK, DONE
//   STOCK_INIT_DEFAULT  stock loaded into each product on reset
//   CNT_MAX_DEFAULT     saturation value for counts and stock
//   sat_add()           add with clamp to a limit
package sales_pkg;

    localparam int NUM_PRODUCTS = 4;

    typedef logic [1:0] prod_id_t;
    typedef logic [3:0] qty_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } sale_state_t;

    localparam qty_t STOCK_INIT_DEFAULT = 4'd5;
    localparam qty_t CNT_MAX_DEFAULT    = 4'd15;

    // Widen to 5 bits so the carry is seen, then clamp to lim.
    function automatic qty_t sat_add(input qty_t a, input qty_t b, input qty_t lim);
        logic [4:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s > {1'b0, lim}) begin
            sat_add = lim;
        end else begin
            sat_add = sum_s[3:0];
        end
    endfunction

endpackage

// File: rtl/sales_slot.sv
// One product's bookkeeping: sold count and remaining stock.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   inc_sale      sale of this product is being committed this edge
//   restock_en    restock of this product is accepted this edge
//   restock_qty   units added by the restock (clamped at CNT_MAX)
//   clr_counts    clear the sold count this edge (stock untouched)
//   count, stock  current register values
// A sale is committed only if stock is nonzero; the slot guards this
// itself so a nak cycle can never underflow the stock.
module sales_slot
    import sales_pkg::*;
#(
    parameter qty_t STOCK_INIT = STOCK_INIT_DEFAULT,
    parameter qty_t CNT_MAX    = CNT_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_sale,
    input  logic       restock_en,
    input  logic [3:0] restock_qty,
    input  logic       clr_counts,
    output logic [3:0] count,
    output logic [3:0] stock
);

    qty_t count_r;
    qty_t stock_r;
    qty_t count_nxt_s;
    qty_t stock_nxt_s;
    logic sell_s;

    assign sell_s = inc_sale && (stock_r != 4'd0);

    // Next-value arithmetic with saturation on count and restocked stock.
    always_comb begin
        count_nxt_s = count_r;
        stock_nxt_s = stock_r;
        if (clr_counts) begin
            count_nxt_s = 4'd0;
        end else if (sell_s) begin
            count_nxt_s = sat_add(count_r, 4'd1, CNT_MAX);
        end else begin
            count_nxt_s = count_r;
        end
        if (restock_en) begin
            stock_nxt_s = sat_add(stock_r, restock_qty, CNT_MAX);
        end else if (sell_s) begin
            stock_nxt_s = stock_r - 4'd1;
        end else begin
            stock_nxt_s = stock_r;
        end
    end

    // Count and stock registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 4'd0;
            stock_r <= STOCK_INIT;
        end else begin
            count_r <= count_nxt_s;
            stock_r <= stock_nxt_s;
        end
    end

    assign count = count_r;
    assign stock = stock_r;

endmodule

// File: rtl/sales_record.sv
// Per-product sales bookkeeping for the four-product vending machine.
// One sale at a time goes IDLE -> CHECK -> DONE; restocks are taken in
// IDLE only when no sale is presented in the same cycle (sale wins).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   sale_valid/sale_id/sale_ready     sale request handshake
//   sale_ack / sale_nak               one-cycle result pulse (DONE cycle)
//   restock_valid/_id/_qty/_ready     restock request handshake
//   count1..count4                    units sold per product
//   stock1..stock4                    units remaining per product
//   sold_out                          bit i set when product i+1 stock is 0
//   clr_counts                        only with SALES_CLEAR_EN defined:
//                                     clear all counts in IDLE
// Build option: define SALES_CLEAR_EN to add the clr_counts input.
module sales_record
    import sales_pkg::*;
#(
    parameter qty_t STOCK_INIT = STOCK_INIT_DEFAULT,
    parameter qty_t CNT_MAX    = CNT_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sale_valid,
    input  logic [1:0] sale_id,
    output logic       sale_ready,
    output logic       sale_ack,
    output logic       sale_nak,
    input  logic       restock_valid,
    input  logic [1:0] restock_id,
    input  logic [3:0] restock_qty,
    output logic       restock_ready,
`ifdef SALES_CLEAR_EN
    input  logic       clr_counts,
`endif
    output logic [3:0] count1,
    output logic [3:0] count2,
    output logic [3:0] count3,
    output logic [3:0] count4,
    output logic [3:0] stock1,
    output logic [3:0] stock2,
    output logic [3:0] stock3,
    output logic [3:0] stock4,
    output logic [3:0] sold_out
);

    sale_state_t state_r;
    sale_state_t state_nxt_s;
    prod_id_t    id_r;
    qty_t        count_s [NUM_PRODUCTS];
    qty_t        stock_s [NUM_PRODUCTS];
    logic        idle_s;
    logic        check_s;
    logic        sale_take_s;
    logic        restock_take_s;
    logic        clr_take_s;
    logic        sale_ok_s;

    assign idle_s         = (state_r == IDLE);
    assign check_s        = (state_r == CHECK);
    assign sale_take_s    = idle_s && sale_valid;
    assign restock_take_s = idle_s && restock_valid && !sale_valid;
    assign sale_ok_s      = (stock_s[id_r] != 4'd0);

`ifdef SALES_CLEAR_EN
    assign clr_take_s = idle_s && clr_counts && !sale_valid;
`else
    assign clr_take_s = 1'b0;
`endif

    assign sale_ready    = idle_s;
    assign restock_ready = idle_s && !sale_valid;

    // Sale FSM next-state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (sale_valid) begin
                    state_nxt_s = CHECK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CHECK:   state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state, latched product id and registered ack/nak pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            id_r     <= 2'd0;
            sale_ack <= 1'b0;
            sale_nak <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (sale_take_s) begin
                id_r <= sale_id;
            end else begin
                id_r <= id_r;
            end
            sale_ack <= check_s && sale_ok_s;
            sale_nak <= check_s && !sale_ok_s;
        end
    end

    for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_slot
        sales_slot #(
            .STOCK_INIT (STOCK_INIT),
            .CNT_MAX    (CNT_MAX)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .inc_sale    (check_s && (id_r == prod_id_t'(g))),
            .restock_en  (restock_take_s && (restock_id == prod_id_t'(g))),
            .restock_qty (restock_qty),
            .clr_counts  (clr_take_s),
            .count       (count_s[g]),
            .stock       (stock_s[g])
        );
        assign sold_out[g] = (stock_s[g] == 4'd0);
    end

    assign count1 = count_s[0];
    assign count2 = count_s[1];
    assign count3 = count_s[2];
    assign count4 = count_s[3];
    assign stock1 = stock_s[0];
    assign stock2 = stock_s[1];
    assign stock3 = stock_s[2];
    assign stock4 = stock_s[3];

endmodule

// File: tb/tb_sales_record.sv
// Self-checking bench for sales_record: a directed vector table, a few
// hand-written multi-cycle sequences and randomized traffic, all checked
// against a transaction-level model of the bookkeeping rules.
module tb_sales_record;

    logic       clk = 1'b0;
    logic       rst;
    logic       sale_valid;
    logic [1:0] sale_id;
    logic       sale_ready, sale_ack, sale_nak;
    logic       restock_valid;
    logic [1:0] restock_id;
    logic [3:0] restock_qty;
    logic       restock_ready;
    logic       clr;
    logic [3:0] count1, count2, count3, count4;
    logic [3:0] stock1, stock2, stock3, stock4;
    logic [3:0] sold_out;
    logic [3:0] cnt_w [4];
    logic [3:0] stk_w [4];

    always #5 clk = ~clk;

    sales_record dut (
        .clk           (clk),
        .rst           (rst),
        .sale_valid    (sale_valid),
        .sale_id       (sale_id),
        .sale_ready    (sale_ready),
        .sale_ack      (sale_ack),
        .sale_nak      (sale_nak),
        .restock_valid (restock_valid),
        .restock_id    (restock_id),
        .restock_qty   (restock_qty),
        .restock_ready (restock_ready),
`ifdef SALES_CLEAR_EN
        .clr_counts    (clr),
`endif
        .count1 (count1), .count2 (count2), .count3 (count3), .count4 (count4),
        .stock1 (stock1), .stock2 (stock2), .stock3 (stock3), .stock4 (stock4),
        .sold_out (sold_out)
    );

    assign cnt_w[0] = count1; assign cnt_w[1] = count2;
    assign cnt_w[2] = count3; assign cnt_w[3] = count4;
    assign stk_w[0] = stock1; assign stk_w[1] = stock2;
    assign stk_w[2] = stock3; assign stk_w[3] = stock4;

    // Reference model: product ledger plus a sale in flight.
    int m_cnt [4];
    int m_stk [4];
    int m_busy;      // 0 free, 1 sale awaiting decision, 2 result showing
    int m_pend;
    bit m_ack, m_nak;

    int vectors = 0;
    int miscompares = 0;
    logic last_ack, last_nak;

    typedef struct {
        bit       sv;
        bit [1:0] sid;
        bit       rv;
        bit [1:0] rid;
        bit [3:0] rq;
        bit       r;
        bit       e_sr, e_rr, e_ack, e_nak;
        bit [1:0] eid;
        bit [3:0] ecnt, estk;
    } vec_t;
    vec_t tbl [13];

    function automatic void cmp(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic check_outputs();
        cmp("sale_ready", sale_ready, (m_busy == 0) ? 1 : 0);
        cmp("restock_ready", restock_ready, (m_busy == 0 && !sale_valid) ? 1 : 0);
        cmp("sale_ack", sale_ack, m_ack);
        cmp("sale_nak", sale_nak, m_nak);
        for (int i = 0; i < 4; i++) begin
            cmp($sformatf("count%0d", i + 1), cnt_w[i], m_cnt[i]);
            cmp($sformatf("stock%0d", i + 1), stk_w[i], m_stk[i]);
            cmp($sformatf("sold_out[%0d]", i), sold_out[i], (m_stk[i] == 0) ? 1 : 0);
        end
    endtask

    // Apply the rules of one clock edge to the ledger.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0;
                m_stk[i] = 5;
            end
            m_busy = 0; m_ack = 0; m_nak = 0;
        end else begin
            m_ack = 0; m_nak = 0;
            if (m_busy == 0) begin
                if (sale_valid) begin
                    m_pend = int'(sale_id);
                    m_busy = 1;
                end else begin
                    if (restock_valid) begin
                        m_stk[restock_id] = m_stk[restock_id] + int'(restock_qty);
                        if (m_stk[restock_id] > 15) m_stk[restock_id] = 15;
                    end
`ifdef SALES_CLEAR_EN
                    if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`endif
                end
            end else if (m_busy == 1) begin
                if (m_stk[m_pend] > 0) begin
                    m_stk[m_pend]--;
                    if (m_cnt[m_pend] < 15) m_cnt[m_pend]++;
                    m_ack = 1;
                end else begin
                    m_nak = 1;
                end
                m_busy = 2;
            end else begin
                m_busy = 0;
            end
        end
    endtask

    task automatic drive(input bit sv, input int sid, input bit rv, input int rid,
                         input int rq, input bit r, input bit c);
        sale_valid    = sv;
        sale_id       = 2'(sid);
        restock_valid = rv;
        restock_id    = 2'(rid);
        restock_qty   = 4'(rq);
        rst           = r;
        clr           = c;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic step(input bit sv, input int sid, input bit rv, input int rid,
                        input int rq, input bit r, input bit c, input bit chk);
        drive(sv, sid, rv, rid, rq, r, c);
        #1;
        last_ack = sale_ack;
        last_nak = sale_nak;
        if (chk) check_outputs();
        advance();
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    // Present a sale for one cycle; last_ack/last_nak hold the result pulse.
    task automatic do_sale(input int id);
        step(1'b1, id, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
    endtask

    initial begin
        // sv sid rv rid rq rst | sr rr ack nak | id cnt stk  (values before the edge)
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 4'd5};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 4'd5};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'd1, 4'd4};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd1, 4'd4};
        tbl[4]  = '{1'b1, 2'd0, 1'b1, 2'd3, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 4'd5};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 2'd3, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 4'd5};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 2'd3, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1, 4'd4};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 2'd3, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd5};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd7};
        tbl[9]  = '{1'b1, 2'd3, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 4'd7};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 4'd7};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd5};
        tbl[12] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd5};

        drive(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        do_reset();

        // Directed table: sale id 2, sale/restock collision, reset in CHECK.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].sv, int'(tbl[i].sid), tbl[i].rv, int'(tbl[i].rid),
                  int'(tbl[i].rq), tbl[i].r, 1'b0);
            #1;
            cmp($sformatf("tbl%0d sale_ready", i), sale_ready, tbl[i].e_sr);
            cmp($sformatf("tbl%0d restock_ready", i), restock_ready, tbl[i].e_rr);
            cmp($sformatf("tbl%0d sale_ack", i), sale_ack, tbl[i].e_ack);
            cmp($sformatf("tbl%0d sale_nak", i), sale_nak, tbl[i].e_nak);
            cmp($sformatf("tbl%0d count", i), cnt_w[tbl[i].eid], tbl[i].ecnt);
            cmp($sformatf("tbl%0d stock", i), stk_w[tbl[i].eid], tbl[i].estk);
            check_outputs();
            advance();
        end

        // Drain product 1 to zero, then one sale too many.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_sale(0);
            cmp("drain ack", last_ack, 1);
        end
        cmp("drain count1", count1, 5);
        cmp("drain stock1", stock1, 0);
        cmp("drain sold_out0", sold_out[0], 1);
        do_sale(0);
        cmp("drain6 nak", last_nak, 1);
        cmp("drain6 ack", last_ack, 0);
        cmp("drain6 count1", count1, 5);

        // Restock clamps at 15; count saturates at 15.
        do_reset();
        step(1'b0, 0, 1'b1, 1, 14, 1'b0, 1'b0, 1'b1);
        idle();
        cmp("sat stock2", stock2, 15);
        for (int i = 0; i < 15; i++) do_sale(1);
        cmp("sat count2", count2, 15);
        cmp("sat stock2 empty", stock2, 0);
        step(1'b0, 0, 1'b1, 1, 3, 1'b0, 1'b0, 1'b1);
        do_sale(1);
        cmp("sat16 ack", last_ack, 1);
        cmp("sat16 count2", count2, 15);
        cmp("sat16 stock2", stock2, 2);

`ifdef SALES_CLEAR_EN
        do_reset();
        for (int i = 0; i < 3; i++) do_sale(0);
        do_sale(1);
        do_sale(3);
        do_sale(3);
        step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        idle();
        cmp("clr count1", count1, 0);
        cmp("clr count2", count2, 0);
        cmp("clr count4", count4, 0);
        cmp("clr stock1", stock1, 2);
        cmp("clr stock2", stock2, 4);
        cmp("clr stock3", stock3, 5);
        cmp("clr stock4", stock4, 3);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 3) == 0, int'($urandom % 4), ($urandom % 2) == 1,
                 int'($urandom % 4), int'($urandom % 16), ($urandom % 50) == 0,
`ifdef SALES_CLEAR_EN
                 ($urandom % 20) == 0,
`else
                 1'b0,
`endif
                 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
